// File: rtl/boot_load_sequencer_if.sv
// Byte-stream handshake carrying the boot image into the sequencer.
// The master drives data/valid; the slave (sequencer) returns ready.
interface boot_load_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/boot_load_sequencer.sv
// Boot loader: takes a length-prefixed byte image, packs little-endian words into memory,
// then hands the memory port to the core and releases the core from reset.
module boot_load_sequencer #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                        clk,
    input  logic                        reset,
    boot_load_sequencer_if.slave        rx,
    input  logic                        boot_req,
    input  logic [31:0]                 core_Adr,
    input  logic                        core_MemWrite,
    input  logic [31:0]                 core_WriteData,
    output logic [31:0]                 mem_Adr,
    output logic                        mem_MemWrite,
    output logic [31:0]                 mem_WriteData,
    output logic                        core_reset,
    output logic                        loading,
    output logic                        load_err,
    output logic [15:0]                 word_count
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_RUN,
        S_ERR
    } state_t;

    state_t      state, state_next;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
    logic        ready;
    logic        accept;

    always_comb begin
        ready      = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
        accept     = rx.rx_valid && ready;
        rx.rx_ready = ready;
        loading    = ready || (state == S_WRITE);
        load_err   = (state == S_ERR);
    end

    always_comb begin
        state_next = state;
        len_full   = {rx.rx_data, len[7:0]};
        case (state)
            S_LEN_LO: if (accept) state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (len_full == '0)
                        state_next = S_RUN;
                    else if (32'(len_full) > MEM_WORDS)
                        state_next = S_ERR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA:   if (accept && byte_idx == 2'd3) state_next = S_WRITE;
            S_WRITE:  state_next = (word_count + 16'd1 == len) ? S_RUN : S_DATA;
            default:  ;
        endcase
        // boot_req overrides every transition, including the RUN/ERR holds
        if (boot_req)
            state_next = S_LEN_LO;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_LEN_LO;
            core_reset <= 1'b1;
        end else begin
            state      <= state_next;
            core_reset <= (state_next != S_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len        <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            word_count <= '0;
        end else if (boot_req) begin
            // a byte accepted alongside boot_req is intentionally dropped here
            len        <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            word_count <= '0;
        end else begin
            case (state)
                S_LEN_LO: if (accept) len[7:0]  <= rx.rx_data;
                S_LEN_HI: if (accept) len[15:8] <= rx.rx_data;
                S_DATA: begin
                    if (accept) begin
                        word_buf[{byte_idx, 3'b000} +: 8] <= rx.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_WRITE:  word_count <= word_count + 16'd1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        mem_Adr       = BASE_ADDR + {14'd0, word_count, 2'b00};
        mem_WriteData = word_buf;
        mem_MemWrite  = (state == S_WRITE) && !boot_req;
        if (state == S_RUN) begin
            mem_Adr       = core_Adr;
            mem_WriteData = core_WriteData;
            mem_MemWrite  = core_MemWrite;
        end
    end

endmodule
